// File: rtl/pattern_counter_hex.sv
// pattern_counter_hex
//   Up/down counter with load, enable and wrap/saturate mode, plus a serial
//   sequence detector with a parametrised pattern, length and overlap mode.
//   The counter's low nibble drives one hex 7-segment digit; dp shows match.
// Ports
//   clk_2        system clock, rising edge
//   reset        asynchronous, active-high
//   count_en     counter advances when 1
//   count_up     1 = increment, 0 = decrement
//   load         synchronous load of data_in (wins over count_en)
//   data_in      load value
//   sat_mode     1 = saturate at 0 / max, 0 = wrap
//   serial_in    detector input, one bit per clock
//   count        counter value
//   tc           terminal count (max when up, 0 when down)
//   match        pattern present in the last PAT_LEN sampled bits
//   match_count  saturating number of matches since reset
//   seg          {dp,g,f,e,d,c,b,a}, active-high
module pattern_counter_hex #(
  parameter int                 NBITS_COUNT = 4,
  parameter int                 PAT_LEN     = 3,
  parameter logic [PAT_LEN-1:0] PATTERN     = 3'b111,
  parameter bit                 OVERLAP     = 1'b1,
  parameter int                 NBITS_MATCH = 8
) (
  input  logic                   clk_2,
  input  logic                   reset,
  input  logic                   count_en,
  input  logic                   count_up,
  input  logic                   load,
  input  logic [NBITS_COUNT-1:0] data_in,
  input  logic                   sat_mode,
  input  logic                   serial_in,
  output logic [NBITS_COUNT-1:0] count,
  output logic                   tc,
  output logic                   match,
  output logic [NBITS_MATCH-1:0] match_count,
  output logic [7:0]             seg
);

  localparam int                     FW   = $clog2(PAT_LEN + 1);
  localparam logic [NBITS_COUNT-1:0] CMAX = '1;
  localparam logic [FW-1:0]          FULL = FW'(PAT_LEN);

  logic [NBITS_COUNT-1:0] count_q, count_d;
  logic [PAT_LEN-1:0]     hist_q, hist_d;
  logic [FW-1:0]          fill_q, fill_d;
  logic [NBITS_MATCH-1:0] mcount_q, mcount_d;
  logic                   match_w;
  logic [6:0]             seg_digit;

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      count_q  <= '0;
      hist_q   <= '0;
      fill_q   <= '0;
      mcount_q <= '0;
    end else begin
      count_q  <= count_d;
      hist_q   <= hist_d;
      fill_q   <= fill_d;
      mcount_q <= mcount_d;
    end
  end

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = data_in;
    end else if (count_en) begin
      if (count_up) begin
        if (count_q == CMAX) count_d = sat_mode ? CMAX : '0;
        else                 count_d = count_q + NBITS_COUNT'(1);
      end else begin
        if (count_q == '0)   count_d = sat_mode ? '0 : CMAX;
        else                 count_d = count_q - NBITS_COUNT'(1);
      end
    end
  end

  // Match only once PAT_LEN bits have been shifted in since reset/clear,
  // so the zeroed history can never fake a match on an all-zero pattern.
  assign match_w = (fill_q == FULL) && (hist_q == PATTERN);

  always_comb begin
    hist_d = PAT_LEN'({hist_q, serial_in});
    fill_d = (fill_q == FULL) ? fill_q : fill_q + FW'(1);
    if (!OVERLAP && match_w) begin
      // Matched bits are consumed: history restarts with only the new bit.
      hist_d    = '0;
      hist_d[0] = serial_in;
      fill_d    = FW'(1);
    end
  end

  always_comb begin
    mcount_d = mcount_q;
    if (match_w && (mcount_q != '1)) mcount_d = mcount_q + NBITS_MATCH'(1);
  end

  always_comb begin
    seg_digit = 7'h3F;
    case (count_q[3:0])
      4'h0: seg_digit = 7'h3F;
      4'h1: seg_digit = 7'h06;
      4'h2: seg_digit = 7'h5B;
      4'h3: seg_digit = 7'h4F;
      4'h4: seg_digit = 7'h66;
      4'h5: seg_digit = 7'h6D;
      4'h6: seg_digit = 7'h7D;
      4'h7: seg_digit = 7'h07;
      4'h8: seg_digit = 7'h7F;
      4'h9: seg_digit = 7'h6F;
      4'hA: seg_digit = 7'h77;
      4'hB: seg_digit = 7'h7C;
      4'hC: seg_digit = 7'h39;
      4'hD: seg_digit = 7'h5E;
      4'hE: seg_digit = 7'h79;
      4'hF: seg_digit = 7'h71;
      default: seg_digit = 7'h3F;
    endcase
  end

  assign count       = count_q;
  assign tc          = count_up ? (count_q == CMAX) : (count_q == '0);
  assign match       = match_w;
  assign match_count = mcount_q;
  assign seg         = {match_w, seg_digit};

endmodule

// File: tb/tb_pattern_counter_hex.sv
module tb_pattern_counter_hex;

  logic       clk_2 = 1'b0;
  logic       reset = 1'b0;
  logic       count_en = 1'b0, count_up = 1'b0, load = 1'b0, sat_mode = 1'b0;
  logic       serial_in = 1'b0;
  logic [3:0] data_in = '0;

  logic [3:0] c_dut, c_nov, c_p4, c_p4n;
  logic       tc_dut, tc_nov, tc_p4, tc_p4n;
  logic       m_dut, m_nov, m_p4, m_p4n;
  logic [7:0] mc_dut, mc_p4, mc_p4n;
  logic [1:0] mc_nov;
  logic [7:0] s_dut, s_nov, s_p4, s_p4n;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] seg_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                              8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  always #5 clk_2 = ~clk_2;

  pattern_counter_hex u_dut (
    .clk_2(clk_2), .reset(reset), .count_en(count_en), .count_up(count_up), .load(load),
    .data_in(data_in), .sat_mode(sat_mode), .serial_in(serial_in), .count(c_dut),
    .tc(tc_dut), .match(m_dut), .match_count(mc_dut), .seg(s_dut));

  pattern_counter_hex #(.OVERLAP(1'b0), .NBITS_MATCH(2)) u_nov (
    .clk_2(clk_2), .reset(reset), .count_en(count_en), .count_up(count_up), .load(load),
    .data_in(data_in), .sat_mode(sat_mode), .serial_in(serial_in), .count(c_nov),
    .tc(tc_nov), .match(m_nov), .match_count(mc_nov), .seg(s_nov));

  pattern_counter_hex #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1)) u_p4 (
    .clk_2(clk_2), .reset(reset), .count_en(count_en), .count_up(count_up), .load(load),
    .data_in(data_in), .sat_mode(sat_mode), .serial_in(serial_in), .count(c_p4),
    .tc(tc_p4), .match(m_p4), .match_count(mc_p4), .seg(s_p4));

  pattern_counter_hex #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0)) u_p4n (
    .clk_2(clk_2), .reset(reset), .count_en(count_en), .count_up(count_up), .load(load),
    .data_in(data_in), .sat_mode(sat_mode), .serial_in(serial_in), .count(c_p4n),
    .tc(tc_p4n), .match(m_p4n), .match_count(mc_p4n), .seg(s_p4n));

  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk_2);
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    count_en = 1'b0; load = 1'b0; serial_in = 1'b0; count_up = 1'b1;
    @(negedge clk_2);
    reset = 1'b1;
    #1;
    tests_run++;
    if (c_dut !== 4'h0) begin tests_failed++; $display("FAIL reset_count got %h exp 0", c_dut); end
    tests_run++;
    if (tc_dut !== 1'b0) begin tests_failed++; $display("FAIL reset_tc_up got %b exp 0", tc_dut); end
    tests_run++;
    if (s_dut !== 8'h3F) begin tests_failed++; $display("FAIL reset_seg got %h exp 3F", s_dut); end
    tests_run++;
    if (m_dut !== 1'b0 || mc_dut !== 8'd0) begin
      tests_failed++; $display("FAIL reset_match got %b/%0d exp 0/0", m_dut, mc_dut);
    end
    count_up = 1'b0;
    #1;
    tests_run++;
    if (tc_dut !== 1'b1) begin tests_failed++; $display("FAIL reset_tc_down got %b exp 1", tc_dut); end
    reset = 1'b0;
  endtask

  task automatic test_count_wrap();
    logic [3:0] exp;
    do_reset();
    count_en = 1'b1; count_up = 1'b1; sat_mode = 1'b0; load = 1'b0; serial_in = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      tick();
      exp = 4'(k % 16);
      tests_run++;
      if (c_dut !== exp || tc_dut !== (exp == 4'hF) || s_dut !== seg_tab[exp]) begin
        tests_failed++;
        $display("FAIL wrap_step%0d got count=%h tc=%b seg=%h exp count=%h tc=%b seg=%h",
                 k, c_dut, tc_dut, s_dut, exp, (exp == 4'hF), seg_tab[exp]);
      end
    end
  endtask

  task automatic test_down_sat();
    // load, data, en, up, sat, expected count, expected tc
    logic       v_ld  [11] = '{0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 1};
    logic [3:0] v_d   [11] = '{0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 4'hA};
    logic       v_en  [11] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
    logic       v_up  [11] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1};
    logic       v_sat [11] = '{1, 1, 1, 1, 1, 0, 0, 1, 0, 0, 0};
    logic [3:0] e_c   [11] = '{0, 0, 5, 4, 3, 0, 4'hF, 4'hF, 4'hF, 4'hF, 4'hA};
    logic       e_tc  [11] = '{1, 1, 0, 0, 0, 1, 0, 1, 0, 1, 0};
    for (int i = 0; i < 11; i++) begin
      load = v_ld[i]; data_in = v_d[i]; count_en = v_en[i];
      count_up = v_up[i]; sat_mode = v_sat[i];
      tick();
      tests_run++;
      if (c_dut !== e_c[i] || tc_dut !== e_tc[i] || s_dut !== seg_tab[e_c[i]]) begin
        tests_failed++;
        $display("FAIL down_sat_vec%0d got count=%h tc=%b seg=%h exp count=%h tc=%b seg=%h",
                 i, c_dut, tc_dut, s_dut, e_c[i], e_tc[i], seg_tab[e_c[i]]);
      end
    end
    load = 1'b0; count_en = 1'b0;
  endtask

  task automatic test_overlap();
    logic bits [6] = '{0, 1, 1, 1, 1, 0};
    logic e_m  [6] = '{0, 0, 0, 1, 1, 0};
    int   e_mc [6] = '{0, 0, 0, 0, 1, 2};
    logic e_nm [6] = '{0, 0, 0, 1, 0, 0};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      serial_in = bits[i];
      tick();
      tests_run++;
      if (m_dut !== e_m[i] || s_dut[7] !== e_m[i] || mc_dut !== 8'(e_mc[i])) begin
        tests_failed++;
        $display("FAIL overlap_bit%0d got match=%b dp=%b mc=%0d exp match=%b dp=%b mc=%0d",
                 i + 1, m_dut, s_dut[7], mc_dut, e_m[i], e_m[i], e_mc[i]);
      end
      tests_run++;
      if (m_nov !== e_nm[i]) begin
        tests_failed++;
        $display("FAIL overlap_nov_bit%0d got match=%b exp %b", i + 1, m_nov, e_nm[i]);
      end
    end
  endtask

  task automatic test_no_overlap();
    logic bits [7] = '{1, 1, 1, 1, 1, 1, 0};
    logic e_nm [7] = '{0, 0, 1, 0, 0, 1, 0};
    int   e_nc [7] = '{0, 0, 0, 1, 1, 1, 2};
    logic e_m  [7] = '{0, 0, 1, 1, 1, 1, 0};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      serial_in = bits[i];
      tick();
      tests_run++;
      if (m_nov !== e_nm[i] || mc_nov !== 2'(e_nc[i]) || m_dut !== e_m[i]) begin
        tests_failed++;
        $display("FAIL no_overlap_bit%0d got nov=%b mc=%0d ovl=%b exp nov=%b mc=%0d ovl=%b",
                 i + 1, m_nov, mc_nov, m_dut, e_nm[i], e_nc[i], e_m[i]);
      end
    end
  endtask

  task automatic test_pat4();
    logic bits [7] = '{1, 0, 1, 1, 0, 1, 1};
    logic e_m  [7] = '{0, 0, 0, 1, 0, 0, 1};
    logic e_nm [7] = '{0, 0, 0, 1, 0, 0, 0};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      serial_in = bits[i];
      tick();
      tests_run++;
      if (m_p4 !== e_m[i] || m_p4n !== e_nm[i]) begin
        tests_failed++;
        $display("FAIL pat4_bit%0d got ovl=%b nov=%b exp ovl=%b nov=%b",
                 i + 1, m_p4, m_p4n, e_m[i], e_nm[i]);
      end
    end
    tests_run++;
    if (mc_p4 !== 8'd1 || mc_p4n !== 8'd1) begin
      tests_failed++;
      $display("FAIL pat4_count got ovl=%0d nov=%0d exp 1/1", mc_p4, mc_p4n);
    end
    serial_in = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic e_m [3] = '{0, 0, 1};
    do_reset();
    load = 1'b1; data_in = 4'h9; count_en = 1'b0; serial_in = 1'b1;
    tick();
    load = 1'b0;
    tick();
    tests_run++;
    if (c_dut !== 4'h9) begin tests_failed++; $display("FAIL mid_preload got %h exp 9", c_dut); end
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if (c_dut !== 4'h0 || s_dut !== 8'h3F || mc_dut !== 8'd0) begin
      tests_failed++;
      $display("FAIL mid_reset_clear got count=%h seg=%h mc=%0d exp 0/3F/0", c_dut, s_dut, mc_dut);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (m_dut !== e_m[i]) begin
        tests_failed++;
        $display("FAIL mid_refill_bit%0d got match=%b exp %b", i + 1, m_dut, e_m[i]);
      end
    end
    serial_in = 1'b0;
  endtask

  task automatic test_sat_match();
    do_reset();
    serial_in = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    tests_run++;
    if (mc_nov !== 2'd3) begin
      tests_failed++; $display("FAIL sat_match_count got %0d exp 3", mc_nov);
    end
    tests_run++;
    if (mc_dut !== 8'd13) begin
      tests_failed++; $display("FAIL wide_match_count got %0d exp 13", mc_dut);
    end
    serial_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count_wrap();
    test_down_sat();
    test_overlap();
    test_no_overlap();
    test_pat4();
    test_reset_mid();
    test_sat_match();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout run did not complete");
    $fatal(1, "timeout");
  end

endmodule
